// File: rtl/rgb_gain_stats.sv
// White-balance gain, round/saturate and 12->8 bit reduction for the D8M RGB
// stream, plus per-frame raw channel sums and a pixel count for AWB software.

module rgb_gain_chan #(
  parameter int unsigned IW   = 12,
  parameter int unsigned OW   = 8,
  parameter int unsigned GW   = 8,
  parameter int unsigned FRAC = 6,
  parameter int unsigned SW   = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_fall,
  input  logic          i_dval,
  input  logic [IW-1:0] i_data,
  input  logic [GW-1:0] i_gain,
  input  logic          i_s2_v,
  output logic [OW-1:0] o_data,
  output logic [SW-1:0] o_sum
);

  localparam int unsigned PW = IW + GW;
  localparam int unsigned QW = PW + 1 - FRAC;
  localparam logic [GW-1:0] UNITY   = GW'(1 << FRAC);
  localparam logic [PW:0]   HALF    = (PW+1)'(1 << (FRAC - 1));
  localparam logic [IW-1:0] MAX_VAL = '1;

  logic [GW-1:0] r_gain;
  logic [IW-1:0] r_s1;
  logic [PW-1:0] r_p;
  logic [OW-1:0] r_out;
  logic [SW-1:0] r_acc;
  logic [SW-1:0] r_sum;

  logic [PW:0]   w_round;
  logic [QW-1:0] w_q;
  logic [IW-1:0] w_sat;
  logic [SW:0]   w_acc_sum;
  logic [SW-1:0] w_acc_sat;

  always_comb begin
    w_round   = (PW+1)'(r_p) + HALF;
    w_q       = QW'(w_round >> FRAC);
    w_sat     = (w_q > QW'(MAX_VAL)) ? MAX_VAL : IW'(w_q);
    w_acc_sum = (SW+1)'(r_acc) + (SW+1)'(i_data);
    w_acc_sat = w_acc_sum[SW] ? '1 : w_acc_sum[SW-1:0];
  end

  // Shadow gain loads on the fall cycle, so the product formed on the next
  // edge (the pixel entering S2) is the first to see it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gain <= UNITY;
      r_s1   <= '0;
      r_p    <= '0;
      r_out  <= '0;
    end else begin
      if (i_fall) begin
        r_gain <= i_gain;
      end
      r_s1  <= i_data;
      r_p   <= PW'(r_s1) * PW'(r_gain);
      r_out <= i_s2_v ? OW'(w_sat >> (IW - OW)) : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_sum <= '0;
    end else if (i_fall) begin
      r_sum <= r_acc;
      r_acc <= i_dval ? SW'(i_data) : '0;
    end else if (i_dval) begin
      r_acc <= w_acc_sat;
    end
  end

  assign o_data = r_out;
  assign o_sum  = r_sum;

endmodule

module rgb_gain_stats #(
  parameter int unsigned IW   = 12,
  parameter int unsigned OW   = 8,
  parameter int unsigned GW   = 8,
  parameter int unsigned FRAC = 6,
  parameter int unsigned SW   = 32,
  parameter int unsigned CW   = 24
) (
  input  logic          VGA_CLK,
  input  logic          RST_N,
  input  logic [IW-1:0] iRed,
  input  logic [IW-1:0] iGreen,
  input  logic [IW-1:0] iBlue,
  input  logic          iDVAL,
  input  logic          VGA_VS,
  input  logic [GW-1:0] iGAIN_R,
  input  logic [GW-1:0] iGAIN_G,
  input  logic [GW-1:0] iGAIN_B,
  output logic [OW-1:0] oRed,
  output logic [OW-1:0] oGreen,
  output logic [OW-1:0] oBlue,
  output logic          oDVAL,
  output logic [SW-1:0] oSUM_R,
  output logic [SW-1:0] oSUM_G,
  output logic [SW-1:0] oSUM_B,
  output logic [CW-1:0] oPIX_CNT,
  output logic          oSTAT_VALID
);

  logic          r_vs_d;
  logic          r_v1;
  logic          r_v2;
  logic          r_v3;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_pix_cnt;
  logic          r_stat_v;

  logic          w_fall;
  logic [CW-1:0] w_cnt_next;

  assign w_fall     = r_vs_d & ~VGA_VS;
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vs_d <= 1'b1;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
    end else begin
      r_vs_d <= VGA_VS;
      r_v1   <= iDVAL;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
    end
  end

  // A pixel coincident with the fall opens the new frame's count.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_pix_cnt <= '0;
      r_stat_v  <= 1'b0;
    end else if (w_fall) begin
      r_pix_cnt <= r_cnt;
      r_cnt     <= iDVAL ? CW'(1) : '0;
      r_stat_v  <= 1'b1;
    end else begin
      r_stat_v  <= 1'b0;
      if (iDVAL) begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  rgb_gain_chan #(.IW(IW), .OW(OW), .GW(GW), .FRAC(FRAC), .SW(SW)) u_chan_r (
    .i_clk   (VGA_CLK),
    .i_rst_n (RST_N),
    .i_fall  (w_fall),
    .i_dval  (iDVAL),
    .i_data  (iRed),
    .i_gain  (iGAIN_R),
    .i_s2_v  (r_v2),
    .o_data  (oRed),
    .o_sum   (oSUM_R)
  );

  rgb_gain_chan #(.IW(IW), .OW(OW), .GW(GW), .FRAC(FRAC), .SW(SW)) u_chan_g (
    .i_clk   (VGA_CLK),
    .i_rst_n (RST_N),
    .i_fall  (w_fall),
    .i_dval  (iDVAL),
    .i_data  (iGreen),
    .i_gain  (iGAIN_G),
    .i_s2_v  (r_v2),
    .o_data  (oGreen),
    .o_sum   (oSUM_G)
  );

  rgb_gain_chan #(.IW(IW), .OW(OW), .GW(GW), .FRAC(FRAC), .SW(SW)) u_chan_b (
    .i_clk   (VGA_CLK),
    .i_rst_n (RST_N),
    .i_fall  (w_fall),
    .i_dval  (iDVAL),
    .i_data  (iBlue),
    .i_gain  (iGAIN_B),
    .i_s2_v  (r_v2),
    .o_data  (oBlue),
    .o_sum   (oSUM_B)
  );

  assign oDVAL       = r_v3;
  assign oPIX_CNT    = r_pix_cnt;
  assign oSTAT_VALID = r_stat_v;

endmodule

// File: tb/tb_rgb_gain_stats.sv
// Directed bench for rgb_gain_stats: gain/rounding/saturation, shadow-gain
// timing, frame statistics, back-to-back frame boundaries and mid-frame reset.

module tb_rgb_gain_stats;

  logic        VGA_CLK = 1'b0;
  logic        RST_N;
  logic [11:0] iRed, iGreen, iBlue;
  logic        iDVAL;
  logic        VGA_VS;
  logic [7:0]  iGAIN_R, iGAIN_G, iGAIN_B;
  logic [7:0]  oRed, oGreen, oBlue;
  logic        oDVAL;
  logic [31:0] oSUM_R, oSUM_G, oSUM_B;
  logic [23:0] oPIX_CNT;
  logic        oSTAT_VALID;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  bit v_tab  [0:16] = '{1,1,1,1,1,0,1,1,1,1,1,1,0,0,0,0,0};
  bit vs_tab [0:16] = '{1,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1,1};

  rgb_gain_stats #(.IW(12), .OW(8), .GW(8), .FRAC(6), .SW(32), .CW(24)) dut (
    .VGA_CLK     (VGA_CLK),
    .RST_N       (RST_N),
    .iRed        (iRed),
    .iGreen      (iGreen),
    .iBlue       (iBlue),
    .iDVAL       (iDVAL),
    .VGA_VS      (VGA_VS),
    .iGAIN_R     (iGAIN_R),
    .iGAIN_G     (iGAIN_G),
    .iGAIN_B     (iGAIN_B),
    .oRed        (oRed),
    .oGreen      (oGreen),
    .oBlue       (oBlue),
    .oDVAL       (oDVAL),
    .oSUM_R      (oSUM_R),
    .oSUM_G      (oSUM_G),
    .oSUM_B      (oSUM_B),
    .oPIX_CNT    (oPIX_CNT),
    .oSTAT_VALID (oSTAT_VALID)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic drive(input logic [11:0] r, input logic [11:0] g,
                       input logic [11:0] b, input logic v);
    iRed   = r;
    iGreen = g;
    iBlue  = b;
    iDVAL  = v;
  endtask

  initial begin
    bit ev;
    RST_N   = 1'b0;
    VGA_VS  = 1'b1;
    iGAIN_R = 8'd64;
    iGAIN_G = 8'd64;
    iGAIN_B = 8'd64;
    drive(12'd0, 12'd0, 12'd0, 1'b0);
    tick();
    tick();
    chk("rst_oRed",   oRed,   0);
    chk("rst_oGreen", oGreen, 0);
    chk("rst_oBlue",  oBlue,  0);
    chk("rst_oDVAL",  oDVAL,  0);
    chk("rst_sumR",   oSUM_R, 0);
    chk("rst_sumG",   oSUM_G, 0);
    chk("rst_sumB",   oSUM_B, 0);
    chk("rst_cnt",    oPIX_CNT, 0);
    chk("rst_stat",   oSTAT_VALID, 0);
    RST_N = 1'b1;
    tick();

    // unity gain, 3-cycle latency
    drive(12'd0, 12'd4000, 12'd0, 1'b1);
    tick();
    drive(12'd0, 12'd0, 12'd0, 1'b0);
    tick();
    chk("lat_early_dval", oDVAL, 0);
    tick();
    chk("unity_dval",  oDVAL,  1);
    chk("unity_green", oGreen, 250);
    chk("unity_red",   oRed,   0);
    tick();
    chk("gap_dval",  oDVAL,  0);
    chk("gap_green", oGreen, 0);

    // fall #1 publishes the single green pixel, loads R=2.0, B=1.5
    iGAIN_R = 8'd128;
    iGAIN_B = 8'd96;
    VGA_VS  = 1'b0;
    tick();
    chk("f1_stat", oSTAT_VALID, 1);
    chk("f1_sumG", oSUM_G, 4000);
    chk("f1_sumR", oSUM_R, 0);
    chk("f1_cnt",  oPIX_CNT, 1);
    VGA_VS = 1'b1;
    tick();
    chk("f1_stat_off", oSTAT_VALID, 0);

    // gain, rounding and saturation
    drive(12'd4000, 12'd0, 12'd100, 1'b1);
    tick();
    drive(12'd2047, 12'd0, 12'd1, 1'b1);
    tick();
    drive(12'd0, 12'd0, 12'd0, 1'b0);
    tick();
    chk("sat_red_4000",  oRed,  255);
    chk("gain_blue_100", oBlue, 9);
    chk("gain_dval1",    oDVAL, 1);
    tick();
    chk("sat_red_2047",  oRed,  255);
    chk("round_blue_1",  oBlue, 0);
    chk("gain_dval2",    oDVAL, 1);
    tick();

    // fall #2 back to unity
    iGAIN_R = 8'd64;
    iGAIN_B = 8'd64;
    VGA_VS  = 1'b0;
    tick();
    chk("f2_stat", oSTAT_VALID, 1);
    chk("f2_sumR", oSUM_R, 6047);
    chk("f2_sumB", oSUM_B, 101);
    chk("f2_cnt",  oPIX_CNT, 2);
    VGA_VS = 1'b1;
    tick();
    tick();

    // 10 valid pixels with one gap, G gain changed mid-frame, fall with a
    // coincident pixel at slot 11
    iGAIN_G = 8'd32;
    for (int s = 0; s < 17; s++) begin
      ev = (s >= 3) ? v_tab[s-3] : 1'b0;
      chk("stream_dval",  oDVAL,  ev);
      chk("stream_red",   oRed,   ev ? 6 : 0);
      chk("stream_green", oGreen, ev ? ((s - 3 >= 11) ? 3 : 6) : 0);
      chk("stream_stat",  oSTAT_VALID, (s == 12) ? 1 : 0);
      if (s == 12) begin
        chk("f3_sumR", oSUM_R, 1000);
        chk("f3_sumG", oSUM_G, 1000);
        chk("f3_sumB", oSUM_B, 1000);
        chk("f3_cnt",  oPIX_CNT, 10);
      end
      if (s == 15) begin
        chk("f3_hold_sumR", oSUM_R, 1000);
        chk("f3_hold_cnt",  oPIX_CNT, 10);
      end
      if (v_tab[s]) drive(12'd100, 12'd100, 12'd100, 1'b1);
      else          drive(12'd0, 12'd0, 12'd0, 1'b0);
      VGA_VS = vs_tab[s];
      tick();
    end

    // back-to-back falls two cycles apart
    iGAIN_R = 8'd128;
    VGA_VS  = 1'b0;
    tick();
    chk("bb1_stat", oSTAT_VALID, 1);
    chk("bb1_sumR", oSUM_R, 100);
    chk("bb1_cnt",  oPIX_CNT, 1);
    VGA_VS = 1'b1;
    drive(12'd7, 12'd0, 12'd0, 1'b1);
    tick();
    chk("bb_gap_stat", oSTAT_VALID, 0);
    VGA_VS = 1'b0;
    drive(12'd0, 12'd0, 12'd0, 1'b0);
    tick();
    chk("bb2_stat", oSTAT_VALID, 1);
    chk("bb2_sumR", oSUM_R, 7);
    chk("bb2_sumG", oSUM_G, 0);
    chk("bb2_cnt",  oPIX_CNT, 1);
    VGA_VS = 1'b1;
    tick();
    chk("bb2_stat_off", oSTAT_VALID, 0);

    // reset mid-frame with data in flight (shadow R gain is 2.0 here)
    for (int i = 0; i < 5; i++) begin
      drive(12'd10, 12'd0, 12'd0, 1'b1);
      tick();
    end
    chk("pre_rst_dval", oDVAL, 1);
    chk("pre_rst_red",  oRed,  1);
    RST_N   = 1'b0;
    iGAIN_R = 8'd200;
    drive(12'd0, 12'd0, 12'd0, 1'b0);
    #1;
    chk("mrst_dval", oDVAL, 0);
    chk("mrst_red",  oRed,  0);
    chk("mrst_sumR", oSUM_R, 0);
    chk("mrst_cnt",  oPIX_CNT, 0);
    chk("mrst_stat", oSTAT_VALID, 0);
    tick();
    tick();
    RST_N = 1'b1;
    drive(12'd1000, 12'd0, 12'd0, 1'b1);
    tick();
    drive(12'd10, 12'd0, 12'd0, 1'b1);
    tick();
    drive(12'd10, 12'd0, 12'd0, 1'b1);
    tick();
    drive(12'd0, 12'd0, 12'd0, 1'b0);
    chk("post_rst_unity_red", oRed,  62);
    chk("post_rst_dval",      oDVAL, 1);
    tick();
    VGA_VS = 1'b0;
    tick();
    chk("post_rst_stat", oSTAT_VALID, 1);
    chk("post_rst_cnt",  oPIX_CNT, 3);
    chk("post_rst_sumR", oSUM_R, 1020);
    chk("post_rst_sumG", oSUM_G, 0);
    VGA_VS = 1'b1;
    tick();
    chk("post_rst_stat_off", oSTAT_VALID, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
